// File: rtl/mat_vec_res_serializer_pkg.sv
// Shared constants, FSM encoding and width helper for the mat-vec result serializer.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package mat_vec_res_serializer_pkg;

    localparam int Y_BYTES_L1 = 104;
    localparam int Y_BYTES_L3 = 159;
    localparam int Y_BYTES_L5 = 202;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int y_bytes_of(input logic [15:0] param_set);
        if (param_set == "L5") begin
            return Y_BYTES_L5;
        end else if (param_set == "L3") begin
            return Y_BYTES_L3;
        end
        return Y_BYTES_L1;
    endfunction

    function automatic int n_words_of(input int y_bytes, input int n_gf);
        return (y_bytes + n_gf - 1) / n_gf;
    endfunction

    function automatic int last_bytes_of(input int y_bytes, input int n_gf);
        return y_bytes - (n_words_of(y_bytes, n_gf) - 1) * n_gf;
    endfunction

endpackage

// File: rtl/mat_vec_res_serializer_word_to_byte_skid.sv
// Word-to-byte converter: current-word shift register plus one prefetch word,
// presenting bytes MSB first on a valid/ready interface.
module word_to_byte_skid
    import mat_vec_res_serializer_pkg::*;
#(
    parameter int N_GF       = 4,
    parameter int LAST_BYTES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_load_last,
    input  logic [N_GF*8-1:0]   i_word,
    output logic                o_pf_free,
    output logic [7:0]          o_byte,
    output logic                o_byte_valid,
    input  logic                i_byte_ready,
    output logic                o_last_xfer
);
    localparam int PROC_SIZE = N_GF * 8;
    localparam int CNT_W     = $clog2(N_GF + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_GF);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BYTES);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [PROC_SIZE-1:0] r_sr;
    logic [PROC_SIZE-1:0] r_pf;
    logic [CNT_W-1:0]     r_sr_cnt;
    logic                 r_sr_last;
    logic                 r_pf_valid;
    logic                 r_pf_last;

    logic                 w_xfer;
    logic                 w_sr_empty_next;
    logic                 w_pf_valid_next;
    logic [CNT_W-1:0]     w_load_cnt;
    logic [CNT_W-1:0]     w_pf_cnt;

    assign w_xfer          = o_byte_valid && i_byte_ready;
    assign w_sr_empty_next = (r_sr_cnt == '0) || ((r_sr_cnt == ONE_CNT) && w_xfer);
    assign w_load_cnt      = i_load_last ? LAST_CNT : FULL_CNT;
    assign w_pf_cnt        = r_pf_last ? LAST_CNT : FULL_CNT;

    // The shift register takes priority for an arriving word, so prefetch only
    // stays occupied when the current word still has bytes left after this edge.
    always_comb begin
        w_pf_valid_next = r_pf_valid || i_load;
        if (w_sr_empty_next) begin
            w_pf_valid_next = r_pf_valid && i_load;
        end
    end

    assign o_pf_free    = !w_pf_valid_next;
    assign o_byte       = r_sr[PROC_SIZE-1 -: 8];
    assign o_byte_valid = (r_sr_cnt != '0);
    assign o_last_xfer  = w_xfer && (r_sr_cnt == ONE_CNT) && r_sr_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr       <= '0;
            r_pf       <= '0;
            r_sr_cnt   <= '0;
            r_sr_last  <= 1'b0;
            r_pf_valid <= 1'b0;
            r_pf_last  <= 1'b0;
        end else begin
            r_pf_valid <= w_pf_valid_next;
            if (w_sr_empty_next) begin
                if (r_pf_valid) begin
                    r_sr      <= r_pf;
                    r_sr_cnt  <= w_pf_cnt;
                    r_sr_last <= r_pf_last;
                    if (i_load) begin
                        r_pf      <= i_word;
                        r_pf_last <= i_load_last;
                    end
                end else if (i_load) begin
                    r_sr      <= i_word;
                    r_sr_cnt  <= w_load_cnt;
                    r_sr_last <= i_load_last;
                end else begin
                    r_sr      <= r_sr << 8;
                    r_sr_cnt  <= '0;
                    r_sr_last <= 1'b0;
                end
            end else begin
                if (w_xfer) begin
                    r_sr     <= r_sr << 8;
                    r_sr_cnt <= r_sr_cnt - ONE_CNT;
                end
                if (i_load) begin
                    r_pf      <= i_word;
                    r_pf_last <= i_load_last;
                end
            end
        end
    end

endmodule

// File: rtl/mat_vec_res_serializer.sv
// Drains the mat-vec result memory in address order and streams y as bytes.
// state  | meaning
// IDLE   | waiting for i_start
// FETCH  | read of word 0 issued
// STREAM | bytes flowing; further reads issued as prefetch space allows
// DONE   | one-cycle completion pulse, then back to IDLE
module mat_vec_res_serializer
    import mat_vec_res_serializer_pkg::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter int          N_GF          = 4,
    parameter int          Y_BYTES       = y_bytes_of(PARAMETER_SET),
    parameter int          PROC_SIZE     = N_GF * 8,
    parameter int          N_WORDS       = n_words_of(Y_BYTES, N_GF),
    parameter int          LAST_BYTES    = last_bytes_of(Y_BYTES, N_GF)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    output logic                          o_res_en,
    output logic [`CLOG2(N_WORDS)-1:0]    o_res_addr,
    input  logic [PROC_SIZE-1:0]          i_res,
    output logic [7:0]                    o_byte,
    output logic                          o_byte_valid,
    input  logic                          i_byte_ready,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int ADDR_W = `CLOG2(N_WORDS);
    localparam int RD_W   = $clog2(N_WORDS + 1);
    localparam logic [RD_W-1:0]   RD_ONE   = RD_W'(1);
    localparam logic [RD_W-1:0]   RD_ALL   = RD_W'(N_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [RD_W-1:0]   r_rd_left;
    logic              r_rd_d;
    logic              r_rd_last_d;

    logic              w_issue;
    logic              w_pf_free;
    logic              w_last_xfer;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_issue      = 1'b1;
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                w_issue = w_pf_free && (r_rd_left != '0);
                if (w_last_xfer) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The address stops on the last word instead of wrapping past N_WORDS-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_rd_left   <= '0;
            r_rd_d      <= 1'b0;
            r_rd_last_d <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_d      <= w_issue;
            r_rd_last_d <= w_issue && (r_rd_left == RD_ONE);
            if ((r_state == ST_IDLE) && i_start) begin
                r_addr    <= '0;
                r_rd_left <= RD_ALL;
            end else if (r_state == ST_DONE) begin
                r_addr <= '0;
            end else if (w_issue) begin
                r_rd_left <= r_rd_left - RD_ONE;
                if (r_rd_left != RD_ONE) begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end
        end
    end

    word_to_byte_skid #(
        .N_GF       (N_GF),
        .LAST_BYTES (LAST_BYTES)
    ) u_skid (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (r_rd_d),
        .i_load_last  (r_rd_last_d),
        .i_word       (i_res),
        .o_pf_free    (w_pf_free),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_last_xfer  (w_last_xfer)
    );

    assign o_res_en   = w_issue;
    assign o_res_addr = r_addr;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_mat_vec_res_serializer.sv
// Bench for mat_vec_res_serializer: L1 and L3 instances driven from a scenario table,
// byte stream compared against the bench's own memory contents.
module tb_mat_vec_res_serializer;
    localparam int Y1 = 104;
    localparam int N1 = 26;
    localparam int Y3 = 159;
    localparam int N3 = 40;
    localparam int BUDGET = 2000;
    localparam int NVEC = 10;

    typedef struct {
        int sel;
        int pct;
        int restart_at;
        int stall_at;
        int stall_len;
        int rst_at;
        int rand_mem;
        int start_in_done;
        int exp_bytes;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st1 = 1'b0, rdy1 = 1'b0, res_en1, valid1, busy1, done1;
    logic st3 = 1'b0, rdy3 = 1'b0, res_en3, valid3, busy3, done3;
    logic [4:0]  addr1;
    logic [5:0]  addr3;
    logic [7:0]  byte1, byte3;
    logic [31:0] res1 = '0, res3 = '0;
    logic [31:0] mem1 [N1];
    logic [31:0] mem3 [N3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sel = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (res_en1) res1 <= mem1[addr1];
        if (res_en3) res3 <= mem3[addr3];
    end

    mat_vec_res_serializer #(.PARAMETER_SET("L1")) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(st1), .o_res_en(res_en1), .o_res_addr(addr1),
        .i_res(res1), .o_byte(byte1), .o_byte_valid(valid1), .i_byte_ready(rdy1),
        .o_busy(busy1), .o_done(done1));

    mat_vec_res_serializer #(.PARAMETER_SET("L3")) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(st3), .o_res_en(res_en3), .o_res_addr(addr3),
        .i_res(res3), .o_byte(byte3), .o_byte_valid(valid3), .i_byte_ready(rdy3),
        .o_busy(busy3), .o_done(done3));

    logic [7:0] m_byte;
    logic [5:0] m_addr;
    logic       m_valid, m_busy, m_done, m_res_en;
    assign m_byte   = (sel == 1) ? byte3   : byte1;
    assign m_addr   = (sel == 1) ? addr3   : {1'b0, addr1};
    assign m_valid  = (sel == 1) ? valid3  : valid1;
    assign m_busy   = (sel == 1) ? busy3   : busy1;
    assign m_done   = (sel == 1) ? done3   : done1;
    assign m_res_en = (sel == 1) ? res_en3 : res_en1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte i of y is byte (i mod 4) of word i/4, most significant first.
    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = (sel == 1) ? mem3[i / 4] : mem1[i / 4];
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    task automatic write_word(input int a, input logic [31:0] d);
        check("mem_write_while_idle", m_busy, 1'b0);
        if (sel == 1) mem3[a] = d;
        else mem1[a] = d;
    endtask

    task automatic fill_mem(input int rnd);
        int n;
        n = (sel == 1) ? N3 : N1;
        for (int w = 0; w < n; w++) begin
            if (rnd != 0) write_word(w, $urandom);
            else write_word(w, {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
        end
        if (sel == 1) write_word(N3 - 1, 32'hAABBCCDD);
    endtask

    task automatic drive(input logic s, input logic r);
        if (sel == 1) begin st3 = s; rdy3 = r; st1 = 1'b0; rdy1 = 1'b0; end
        else          begin st1 = s; rdy1 = r; st3 = 1'b0; rdy3 = 1'b0; end
    endtask

    int n_bytes, first_lat, first_cyc, last_cyc, n_reads, stall_cnt, stall_reads, dd_cnt;
    int done_seen;
    logic [7:0] last_byte;

    task automatic run(input vec_t v);
        int n, cyc0;
        logic rdy, s, stalling, prev_hold;
        logic [7:0] prev_byte;
        int restarted;
        n = (sel == 1) ? N3 : N1;
        n_bytes = 0; first_lat = -1; first_cyc = 0; last_cyc = 0; n_reads = 0;
        stall_cnt = 0; stall_reads = 0; dd_cnt = 0; done_seen = 0; last_byte = 8'h00;
        prev_hold = 1'b0; prev_byte = 8'h00; restarted = 0;

        @(negedge clk); drive(1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0); #1;
        cyc0 = cyc;
        check("start_busy", m_busy, 1'b1);
        check("start_res_en", m_res_en, 1'b1);
        check("start_addr", m_addr, 0);
        check("start_no_valid", m_valid, 1'b0);
        n_reads = 1;

        for (int t = 0; t < BUDGET; t++) begin
            @(negedge clk);
            if (v.rst_at >= 0 && n_bytes == v.rst_at) begin
                rst = 1'b1; drive(1'b0, 1'b0);
                @(negedge clk); #1;
                check("rst_byte", m_byte, 8'h00);
                check("rst_valid", m_valid, 1'b0);
                check("rst_busy", m_busy, 1'b0);
                check("rst_done", m_done, 1'b0);
                check("rst_res_en", m_res_en, 1'b0);
                check("rst_addr", m_addr, 0);
                rst = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk); #1;
                    check("post_rst_no_valid", m_valid, 1'b0);
                    check("post_rst_idle", m_busy, 1'b0);
                end
                break;
            end
            stalling = (v.stall_len > 0) && (n_bytes == v.stall_at) &&
                       (stall_cnt < v.stall_len) && m_valid;
            if (stalling) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = ($urandom_range(99) < v.pct);
            end
            s = (v.restart_at >= 0) && (restarted == 0) && (n_bytes == v.restart_at);
            if (s) restarted = 1;
            drive(s, rdy); #1;

            if (prev_hold) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_byte", m_byte, prev_byte);
            end
            check("addr_range", (int'(m_addr) <= n - 1), 1'b1);
            if (m_res_en) begin
                check("read_state", m_busy && !m_done, 1'b1);
                check("read_addr_order", m_addr, n_reads);
                n_reads++;
                if (stalling) stall_reads++;
            end
            if (m_valid && first_lat < 0) begin
                first_lat = cyc - cyc0 + 1;
                first_cyc = cyc;
            end
            if (m_done) begin
                check("done_after_last", cyc, last_cyc + 1);
                done_seen = 1;
                if (v.start_in_done != 0) drive(1'b1, 1'b0);
                break;
            end
            if (m_valid && rdy) begin
                check("byte", m_byte, exp_byte(n_bytes));
                last_byte = m_byte;
                if (m_byte == 8'hDD) dd_cnt++;
                last_cyc = cyc;
                n_bytes++;
            end
            prev_hold = m_valid && !rdy;
            prev_byte = m_byte;
        end

        if (done_seen != 0) begin
            @(negedge clk); drive(1'b0, 1'b0); #1;
            check("done_one_cycle", m_done, 1'b0);
            check("idle_after_done", m_busy, 1'b0);
            repeat (3) @(negedge clk);
            #1 check("stays_idle", m_busy, 1'b0);
        end else begin
            drive(1'b0, 1'b0);
        end
    endtask

    vec_t vecs [NVEC];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        void'($urandom(2024));
        //            sel pct  rst_ at stall_at len  rst_at rnd sid  bytes done
        vecs[0] = '{0, 100, -1, -1, 0,  -1, 0, 0, Y1, 1};
        vecs[1] = '{0, 50,  -1, -1, 0,  -1, 0, 0, Y1, 1};
        vecs[2] = '{0, 100, 50, -1, 0,  -1, 0, 1, Y1, 1};
        vecs[3] = '{0, 100, -1, -1, 0,  -1, 0, 0, Y1, 1};
        vecs[4] = '{0, 100, -1, -1, 0,  30, 0, 0, 30, 0};
        vecs[5] = '{0, 100, -1, -1, 0,  -1, 0, 0, Y1, 1};
        vecs[6] = '{0, 100, -1, 3,  20, -1, 0, 0, Y1, 1};
        vecs[7] = '{0, 70,  -1, -1, 0,  -1, 1, 0, Y1, 1};
        vecs[8] = '{1, 100, -1, -1, 0,  -1, 0, 0, Y3, 1};
        vecs[9] = '{1, 50,  -1, -1, 0,  -1, 0, 0, Y3, 1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid_l1", valid1, 1'b0);
        check("reset_busy_l1", busy1, 1'b0);
        check("reset_res_en_l1", res_en1, 1'b0);
        check("reset_addr_l1", addr1, 0);
        check("reset_byte_l1", byte1, 8'h00);
        check("reset_done_l1", done1, 1'b0);
        check("reset_valid_l3", valid3, 1'b0);
        check("reset_busy_l3", busy3, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            sel = vecs[i].sel;
            fill_mem(vecs[i].rand_mem);
            run(vecs[i]);
            check("first_valid_latency", first_lat, 3);
            check("byte_count", n_bytes, vecs[i].exp_bytes);
            check("done_seen", done_seen, vecs[i].exp_done);
            if (vecs[i].exp_done != 0)
                check("reads_issued", n_reads, (sel == 1) ? N3 : N1);
            if (vecs[i].exp_done != 0 && vecs[i].pct == 100 && vecs[i].stall_len == 0)
                check("no_bubbles", last_cyc - first_cyc, vecs[i].exp_bytes - 1);
            if (vecs[i].stall_len > 0) begin
                check("stall_cycles", stall_cnt, vecs[i].stall_len);
                check("stall_reads_at_most_one", (stall_reads <= 1), 1'b1);
            end
            if (sel == 1 && vecs[i].exp_done != 0) begin
                check("l3_last_byte", last_byte, 8'hCC);
                check("l3_pad_never_sent", dd_cnt, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
